cc_line_fill_engine: RTL and testbench

// - Cache-controller refill path. Takes AXI R-channel beats from memory for
//   the miss at the head of the miss-address FIFO and assembles a full line.
// - Beats are placed critical-word-first with wrap. Writes the line plus a

---
 rtl/cc_line_fill_engine.sv | 177 +++++++++++++++++
 tb/tb_cc_line_fill_engine.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_line_fill_engine.sv
// cc_line_fill_engine: cache refill path.
// Collects R-channel beats for the miss at the head of the miss-address FIFO.
// Beats land in the line critical-word-first, wrapping around the line. The
// assembled line and a valid tag are written to the tag/data SRAM, and then
// the FIFO head is popped. An early RLAST discards the entry. A missing RLAST
// drains the extra beats and still writes the line. Both report fill_err_o.
// Optional feature macro: CC_CRIT_WORD_FWD_EN (critical-word forwarding).
module cc_line_fill_engine #(
    parameter int DATA_W  = 64,
    parameter int BEATS   = 8,
    parameter int INDEX_W = 9,
    parameter int TAG_W   = 17,
    localparam int OFF_W  = $clog2(BEATS),
    localparam int ADDR_W = TAG_W + INDEX_W + OFF_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       mem_rdata_i,
    input  logic                    mem_rlast_i,
    input  logic                    mem_rvalid_i,
    output logic                    mem_rready_o,
    input  logic                    miss_addr_fifo_empty_i,
    input  logic [ADDR_W-1:0]       miss_addr_fifo_rdata_i,
    output logic                    miss_addr_fifo_rden_o,
    output logic                    wren_o,
    output logic [INDEX_W-1:0]      waddr_o,
    output logic [TAG_W:0]          wdata_tag_o,
    output logic [DATA_W*BEATS-1:0] wdata_data_o,
    output logic                    fill_err_o,
    output logic                    fwd_valid_o,
    output logic [DATA_W-1:0]       fwd_data_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [OFF_W-1:0]          r_cnt;
    logic [DATA_W*BEATS-1:0]   r_line;
    logic                      r_err;
    // An early-RLAST discard pops the FIFO one cycle after the error pulse,
    // so the pop never coincides with fill_err_o.
    logic                      r_disc1;
    logic                      r_disc2;

    logic [TAG_W-1:0]          w_tag;
    logic [INDEX_W-1:0]        w_idx;
    logic [OFF_W-1:0]          w_off;
    logic [OFF_W-1:0]          w_slot;
    logic                      w_rready;
    logic                      w_hs;
    logic                      w_cnt_last;
    logic                      w_fill_hs;
    logic                      w_early;
    logic                      w_miss;

    // The FIFO head is show-ahead and stays stable until it is popped.
    assign w_tag      = miss_addr_fifo_rdata_i[ADDR_W-1 -: TAG_W];
    assign w_idx      = miss_addr_fifo_rdata_i[OFF_W +: INDEX_W];
    assign w_off      = miss_addr_fifo_rdata_i[OFF_W-1:0];

    assign w_rready   = (r_state == S_FILL) || (r_state == S_DRAIN);
    assign w_hs       = mem_rvalid_i & w_rready;
    assign w_cnt_last = (r_cnt == OFF_W'(BEATS - 1));
    assign w_fill_hs  = (r_state == S_FILL) & w_hs;
    // The OFF_W-bit add wraps naturally, which gives critical-word-first order.
    assign w_slot     = w_off + r_cnt;
    assign w_early    = w_fill_hs & mem_rlast_i & ~w_cnt_last;
    assign w_miss     = w_fill_hs & ~mem_rlast_i & w_cnt_last;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!miss_addr_fifo_empty_i && !r_disc1 && !r_disc2)
                    w_next = S_FILL;
            end
            S_FILL: begin
                if (w_hs) begin
                    if (mem_rlast_i) w_next = w_cnt_last ? S_WRITE : S_IDLE;
                    else if (w_cnt_last) w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_hs && mem_rlast_i) w_next = S_WRITE;
            end
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from the registered state and the error/discard flops
    always_comb begin
        mem_rready_o          = w_rready;
        wren_o                = (r_state == S_WRITE);
        miss_addr_fifo_rden_o = (r_state == S_WRITE) | r_disc2;
        fill_err_o            = r_err;
        waddr_o               = '0;
        wdata_tag_o           = '0;
        wdata_data_o          = r_line;
        if (r_state == S_WRITE) begin
            waddr_o     = w_idx;
            wdata_tag_o = {1'b1, w_tag};
        end
    end

    // Beat counter: cleared while idle, advanced on every fill handshake
    always_ff @(posedge clk) begin
        if (!rst_n)              r_cnt <= '0;
        else if (r_state == S_IDLE) r_cnt <= '0;
        else if (w_fill_hs)      r_cnt <= r_cnt + 1'b1;
    end

    // Line buffer: each fill beat goes into its wrapped slot; drained beats are dropped
    always_ff @(posedge clk) begin
        if (!rst_n)         r_line <= '0;
        else if (w_fill_hs) r_line[w_slot*DATA_W +: DATA_W] <= mem_rdata_i;
    end

    // Protocol error pulse and the delayed discard pop after an early RLAST
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err   <= 1'b0;
            r_disc1 <= 1'b0;
            r_disc2 <= 1'b0;
        end else begin
            r_err   <= w_early | w_miss;
            r_disc1 <= w_early;
            r_disc2 <= r_disc1;
        end
    end

`ifdef CC_CRIT_WORD_FWD_EN
    logic              r_fwd_valid;
    logic [DATA_W-1:0] r_fwd_data;
    logic              w_crit;

    assign w_crit = w_fill_hs & (r_cnt == '0);

    // Capture the first beat of each fill so it can be forwarded early
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fwd_valid <= 1'b0;
            r_fwd_data  <= '0;
        end else begin
            r_fwd_valid <= w_crit;
            if (w_crit) r_fwd_data <= mem_rdata_i;
        end
    end

    assign fwd_valid_o = r_fwd_valid;
    assign fwd_data_o  = r_fwd_data;
`else
    assign fwd_valid_o = 1'b0;
    assign fwd_data_o  = '0;
`endif

    // The SRAM write always carries the FIFO pop with it
    a_wren_pops: assert property (@(posedge clk) disable iff (!rst_n)
        wren_o |-> miss_addr_fifo_rden_o);
    // Error pulses stay apart from the write and the pop
    a_err_alone: assert property (@(posedge clk) disable iff (!rst_n)
        fill_err_o |-> !(wren_o || miss_addr_fifo_rden_o));

endmodule

// File: tb/tb_cc_line_fill_engine.sv
// Testbench for cc_line_fill_engine. It uses random beat data and gaps and
// checks the results against a line-assembly model that works from slot
// arithmetic.
module tb_cc_line_fill_engine;
    localparam int DATA_W  = 64;
    localparam int BEATS   = 8;
    localparam int INDEX_W = 9;
    localparam int TAG_W   = 17;
    localparam int OFF_W   = $clog2(BEATS);
    localparam int ADDR_W  = TAG_W + INDEX_W + OFF_W;
    localparam int LW      = DATA_W * BEATS;

    logic              clk = 0;
    logic              rst_n;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rlast, mem_rvalid, mem_rready;
    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_rdata;
    logic              rden, wren, fill_err, fwd_valid;
    logic [INDEX_W-1:0] waddr;
    logic [TAG_W:0]    wtag;
    logic [LW-1:0]     wdata;
    logic [DATA_W-1:0] fwd_data;

    cc_line_fill_engine #(.DATA_W(DATA_W), .BEATS(BEATS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_rdata_i(mem_rdata), .mem_rlast_i(mem_rlast), .mem_rvalid_i(mem_rvalid),
        .mem_rready_o(mem_rready),
        .miss_addr_fifo_empty_i(fifo_empty), .miss_addr_fifo_rdata_i(fifo_rdata),
        .miss_addr_fifo_rden_o(rden),
        .wren_o(wren), .waddr_o(waddr), .wdata_tag_o(wtag), .wdata_data_o(wdata),
        .fill_err_o(fill_err), .fwd_valid_o(fwd_valid), .fwd_data_o(fwd_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Miss FIFO model plus output monitor, evaluated at the falling edge
    logic [ADDR_W-1:0] q[$];
    int wren_cnt, rden_cnt, err_cnt, fwd_cnt, overlap, wren_cyc, err_cyc, fwd_cyc;
    logic [DATA_W-1:0] fwd_last;
    logic [INDEX_W-1:0] cap_addr[$];
    logic [TAG_W:0]    cap_tag[$];
    logic [LW-1:0]     cap_data[$];

    always @(negedge clk) begin
        if (wren === 1'b1) begin
            wren_cnt++; wren_cyc = cyc;
            cap_addr.push_back(waddr); cap_tag.push_back(wtag); cap_data.push_back(wdata);
        end
        if (fill_err === 1'b1) begin err_cnt++; err_cyc = cyc; end
        if (fwd_valid === 1'b1) begin fwd_cnt++; fwd_cyc = cyc; fwd_last = fwd_data; end
        if (fill_err === 1'b1 && (rden === 1'b1 || wren === 1'b1)) overlap++;
        if (wren === 1'b1 && rden !== 1'b1) overlap++;
        if (rden === 1'b1) begin
            rden_cnt++;
            if (q.size() > 0) void'(q.pop_front());
        end
        fifo_empty = (q.size() == 0);
        fifo_rdata = (q.size() > 0) ? q[0] : '0;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    logic [DATA_W-1:0] bt[16];
    int hs_edge[16];

    task automatic clr();
        wren_cnt = 0; rden_cnt = 0; err_cnt = 0; fwd_cnt = 0; overlap = 0;
        wren_cyc = -1; err_cyc = -1; fwd_cyc = -1;
        cap_addr.delete(); cap_tag.delete(); cap_data.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Reference: beat i lands in slot (off+i) mod BEATS
    function automatic logic [LW-1:0] model_line(input int off);
        logic [LW-1:0] m = '0;
        for (int i = 0; i < BEATS; i++) m[((off + i) % BEATS)*DATA_W +: DATA_W] = bt[i];
        return m;
    endfunction

    function automatic logic [ADDR_W-1:0] mk_addr(input int tag, input int idx, input int off);
        logic [ADDR_W-1:0] a;
        a = {TAG_W'(tag), INDEX_W'(idx), OFF_W'(off)};
        return a;
    endfunction

    // Drives n beats from bt[]; rlast on beat last_at; up to gmax idle cycles before each beat
    task automatic send_burst(input int n, input int last_at, input int gmax);
        for (int i = 0; i < n; i++) begin
            int budget = 0;
            logic rdy;
            mem_rvalid = 0; mem_rlast = 0;
            tick($urandom_range(gmax, 0));
            mem_rvalid = 1; mem_rdata = bt[i]; mem_rlast = (i == last_at);
            forever begin
                rdy = mem_rready;
                @(posedge clk); #1;
                if (rdy) break;
                budget++;
                if (budget > 100) begin
                    n_cmp++; n_bad++;
                    $display("FAIL hs_timeout beat %0d: got no rready, want handshake", i);
                    break;
                end
            end
            hs_edge[i] = cyc;
        end
        mem_rvalid = 0; mem_rlast = 0;
    endtask

    task automatic rand_beats();
        for (int i = 0; i < 16; i++) bt[i] = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        rst_n = 0; mem_rvalid = 0; mem_rlast = 0; mem_rdata = '0;
        clr();
        tick(3);
        n_cmp++; if (mem_rready !== 1'b0) begin n_bad++; $display("FAIL rst_rready: got %b want 0", mem_rready); end
        n_cmp++; if ({wren, rden, fill_err, fwd_valid} !== 4'b0) begin n_bad++; $display("FAIL rst_pulses: got %b want 0000", {wren, rden, fill_err, fwd_valid}); end
        n_cmp++; if (wdata !== '0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", wdata); end
        n_cmp++; if ({waddr, wtag, fwd_data} !== '0) begin n_bad++; $display("FAIL rst_addr_tag_fwd: got %h want 0", {waddr, wtag, fwd_data}); end
        rst_n = 1;
        tick(2);
        n_cmp++; if (mem_rready !== 1'b0) begin n_bad++; $display("FAIL idle_rready: got %b want 0", mem_rready); end
    endtask

    task automatic test_basic();
        clr();
        for (int i = 0; i < BEATS; i++) bt[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        q.push_back(mk_addr(17'h1ABCD, 9'h055, 0));
        send_burst(BEATS, BEATS - 1, 0);
        tick(4);
        n_cmp++; if (wren_cnt !== 1 || rden_cnt !== 1) begin n_bad++; $display("FAIL basic_counts: got wren %0d rden %0d want 1 1", wren_cnt, rden_cnt); end
        n_cmp++; if (wren_cyc !== hs_edge[BEATS-1]) begin n_bad++; $display("FAIL basic_latency: got edge %0d want %0d", wren_cyc, hs_edge[BEATS-1]); end
        if (cap_data.size() > 0) begin
            n_cmp++; if (cap_addr[0] !== 9'h055) begin n_bad++; $display("FAIL basic_waddr: got %h want 055", cap_addr[0]); end
            n_cmp++; if (cap_tag[0] !== {1'b1, 17'h1ABCD}) begin n_bad++; $display("FAIL basic_tag: got %h want %h", cap_tag[0], {1'b1, 17'h1ABCD}); end
            n_cmp++; if (cap_data[0] !== model_line(0)) begin n_bad++; $display("FAIL basic_line: got %h want %h", cap_data[0], model_line(0)); end
        end
        n_cmp++; if (err_cnt !== 0 || overlap !== 0) begin n_bad++; $display("FAIL basic_err: got err %0d overlap %0d want 0 0", err_cnt, overlap); end
    endtask

    task automatic test_wrap_fwd();
        clr();
        rand_beats();
        q.push_back(mk_addr($urandom, $urandom, 5));
        send_burst(BEATS, BEATS - 1, 3);
        tick(4);
        n_cmp++; if (cap_data.size() !== 1) begin n_bad++; $display("FAIL wrap_count: got %0d want 1", cap_data.size()); end
        else begin
            n_cmp++; if (cap_data[0] !== model_line(5)) begin n_bad++; $display("FAIL wrap_line: got %h want %h", cap_data[0], model_line(5)); end
        end
`ifdef CC_CRIT_WORD_FWD_EN
        n_cmp++; if (fwd_cnt !== 1 || fwd_cyc !== hs_edge[0]) begin n_bad++; $display("FAIL fwd_pulse: got cnt %0d edge %0d want 1 %0d", fwd_cnt, fwd_cyc, hs_edge[0]); end
        n_cmp++; if (fwd_data !== bt[0]) begin n_bad++; $display("FAIL fwd_data: got %h want %h", fwd_data, bt[0]); end
`else
        n_cmp++; if (fwd_cnt !== 0 || fwd_data !== '0) begin n_bad++; $display("FAIL fwd_tied: got cnt %0d data %h want 0 0", fwd_cnt, fwd_data); end
`endif
    endtask

    task automatic test_idle_stall();
        int rdy_hi = 0, wait_n = 0, off;
        clr();
        mem_rvalid = 1; mem_rdata = {$urandom, $urandom}; mem_rlast = 1;
        for (int i = 0; i < 6; i++) begin tick(1); if (mem_rready !== 1'b0) rdy_hi++; end
        n_cmp++; if (rdy_hi !== 0) begin n_bad++; $display("FAIL stall_rready: got %0d high cycles want 0", rdy_hi); end
        n_cmp++; if (wren_cnt !== 0 || rden_cnt !== 0) begin n_bad++; $display("FAIL stall_pulses: got wren %0d rden %0d want 0 0", wren_cnt, rden_cnt); end
        mem_rvalid = 0; mem_rlast = 0;
        off = $urandom_range(BEATS - 1, 0);
        q.push_back(mk_addr($urandom, $urandom, off));
        while (mem_rready !== 1'b1 && wait_n < 5) begin tick(1); wait_n++; end
        n_cmp++; if (mem_rready !== 1'b1 || wait_n > 2) begin n_bad++; $display("FAIL stall_start: got rready %b after %0d cycles want 1 within 2", mem_rready, wait_n); end
        rand_beats();
        send_burst(BEATS, BEATS - 1, 4);
        tick(4);
        n_cmp++; if (cap_data.size() !== 1) begin n_bad++; $display("FAIL gap_count: got %0d want 1", cap_data.size()); end
        else begin
            n_cmp++; if (cap_data[0] !== model_line(off)) begin n_bad++; $display("FAIL gap_line: got %h want %h", cap_data[0], model_line(off)); end
        end
    endtask

    task automatic test_early_last();
        clr();
        rand_beats();
        q.push_back(mk_addr($urandom, $urandom, $urandom_range(BEATS - 1, 0)));
        send_burst(3, 2, 1);
        tick(6);
        n_cmp++; if (err_cnt !== 1 || err_cyc !== hs_edge[2]) begin n_bad++; $display("FAIL early_err: got cnt %0d edge %0d want 1 %0d", err_cnt, err_cyc, hs_edge[2]); end
        n_cmp++; if (rden_cnt !== 1 || wren_cnt !== 0) begin n_bad++; $display("FAIL early_pulses: got rden %0d wren %0d want 1 0", rden_cnt, wren_cnt); end
        n_cmp++; if (overlap !== 0 || q.size() !== 0) begin n_bad++; $display("FAIL early_pop: got overlap %0d qsize %0d want 0 0", overlap, q.size()); end
        n_cmp++; if (mem_rready !== 1'b0) begin n_bad++; $display("FAIL early_idle: got rready %b want 0", mem_rready); end
    endtask

    task automatic test_missing_last();
        int off;
        clr();
        rand_beats();
        off = $urandom_range(BEATS - 1, 0);
        q.push_back(mk_addr($urandom, $urandom, off));
        send_burst(BEATS + 2, BEATS + 1, 2);
        tick(4);
        n_cmp++; if (err_cnt !== 1 || err_cyc !== hs_edge[BEATS-1]) begin n_bad++; $display("FAIL miss_err: got cnt %0d edge %0d want 1 %0d", err_cnt, err_cyc, hs_edge[BEATS-1]); end
        n_cmp++; if (wren_cnt !== 1 || wren_cyc !== hs_edge[BEATS+1]) begin n_bad++; $display("FAIL miss_wren: got cnt %0d edge %0d want 1 %0d", wren_cnt, wren_cyc, hs_edge[BEATS+1]); end
        if (cap_data.size() > 0) begin
            n_cmp++; if (cap_data[0] !== model_line(off)) begin n_bad++; $display("FAIL miss_line: got %h want %h", cap_data[0], model_line(off)); end
        end
        n_cmp++; if (overlap !== 0 || rden_cnt !== 1) begin n_bad++; $display("FAIL miss_pop: got overlap %0d rden %0d want 0 1", overlap, rden_cnt); end
    endtask

    task automatic test_reset_mid();
        int bad_out = 0, off, tag, idx;
        clr();
        rand_beats();
        off = $urandom_range(BEATS - 1, 0); tag = $urandom; idx = $urandom;
        q.push_back(mk_addr(tag, idx, off));
        send_burst(3, 99, 1);
        rst_n = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if ({mem_rready, wren, rden, fill_err, fwd_valid} !== 5'b0 || wdata !== '0) bad_out++;
        end
        n_cmp++; if (bad_out !== 0) begin n_bad++; $display("FAIL rstmid_outputs: got %0d nonzero cycles want 0", bad_out); end
        n_cmp++; if (wren_cnt !== 0 || rden_cnt !== 0 || q.size() !== 1) begin n_bad++; $display("FAIL rstmid_drop: got wren %0d rden %0d qsize %0d want 0 0 1", wren_cnt, rden_cnt, q.size()); end
        rst_n = 1;
        rand_beats();
        send_burst(BEATS, BEATS - 1, 2);
        tick(4);
        n_cmp++; if (cap_data.size() !== 1) begin n_bad++; $display("FAIL rstmid_count: got %0d want 1", cap_data.size()); end
        else begin
            n_cmp++; if (cap_data[0] !== model_line(off) || cap_tag[0] !== {1'b1, TAG_W'(tag)}) begin n_bad++; $display("FAIL rstmid_line: got %h want %h", cap_data[0], model_line(off)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] exp_l[$];
        logic [INDEX_W-1:0] exp_a[$];
        logic [TAG_W:0] exp_t[$];
        int offs[3];
        clr();
        for (int k = 0; k < 3; k++) begin
            int tag = $urandom, idx = $urandom;
            offs[k] = $urandom_range(BEATS - 1, 0);
            q.push_back(mk_addr(tag, idx, offs[k]));
            exp_a.push_back(INDEX_W'(idx)); exp_t.push_back({1'b1, TAG_W'(tag)});
        end
        for (int k = 0; k < 3; k++) begin
            rand_beats();
            exp_l.push_back(model_line(offs[k]));
            send_burst(BEATS, BEATS - 1, (k == 1) ? 0 : 2);
        end
        tick(5);
        n_cmp++; if (cap_data.size() !== 3 || rden_cnt !== 3) begin n_bad++; $display("FAIL b2b_count: got wren %0d rden %0d want 3 3", cap_data.size(), rden_cnt); end
        else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (cap_data[k] !== exp_l[k] || cap_addr[k] !== exp_a[k] || cap_tag[k] !== exp_t[k]) begin
                    n_bad++; $display("FAIL b2b_fill%0d: got idx %h tag %h want idx %h tag %h", k, cap_addr[k], cap_tag[k], exp_a[k], exp_t[k]);
                end
            end
        end
    endtask

    initial begin
        fifo_empty = 1; fifo_rdata = '0;
        test_reset();
        test_basic();
        test_wrap_fwd();
        test_idle_stall();
        test_early_last();
        test_missing_last();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
